// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix-keypad scanner with debounce and an event FIFO.
// Drives active-low one-cold rows and senses active-low columns. Each
// debounced press pushes one scan code (row*COLS + col) into a small FIFO
// that is drained through a valid/ready handshake.
// Optional feature macro: KEYPAD_REPEAT_EN. It adds auto-repeat of the held
// key every REPEAT_TICKS scan ticks.
module keypad_scan_fifo #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE     = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_TICKS = 250,
  parameter int CODE_W       = $clog2(ROWS*COLS)
) (
  input  logic              MAX10_CLK1_50,
  input  logic              rst,
  output logic [ROWS-1:0]   row_drive,
  input  logic [COLS-1:0]   col_sense,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              overflow
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int DVW = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  // Parameter sanity, evaluated at elaboration only.
  generate
    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 4 ||
        DEBOUNCE < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        REPEAT_TICKS < 1) begin : g_param_err
      $error("keypad_scan_fifo: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {S_SCAN, S_DEB, S_HELD} state_t;

  logic              clk;
  assign clk = MAX10_CLK1_50;

  // ---------------------------------------------------------------- sync
  logic [COLS-1:0]   r_sync1, r_sync2;
  logic [COLS-1:0]   w_c_act;

  // Two-flop synchroniser; idle (all high) out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= col_sense;
      r_sync2 <= r_sync1;
    end
  end

  assign w_c_act = ~r_sync2;

  // ---------------------------------------------------------------- tick
  logic [DVW-1:0]    r_div;
  logic              w_tick;

  assign w_tick = (r_div == DVW'(SCAN_DIV - 1));

  // Free-running scan divider; every FSM decision waits for w_tick.
  always_ff @(posedge clk) begin
    if (!rst)        r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DVW'(1);
  end

  // ---------------------------------------------------------------- decode
  logic [CW-1:0]     w_first_col;
  logic [CODE_W-1:0] w_code_now;

  // Lowest active column wins when several keys share the row.
  always_comb begin
    w_first_col = '0;
    for (int i = COLS - 1; i >= 0; i--)
      if (w_c_act[i]) w_first_col = CW'(i);
  end

  // ---------------------------------------------------------------- FSM
  state_t            r_state, w_state_nxt;
  logic [RW-1:0]     r_row_idx, w_row_nxt;
  logic [ROWS-1:0]   r_row_drive;
  logic [DBW-1:0]    r_db_cnt, w_db_nxt;
  logic [DBW-1:0]    r_rel_cnt, w_rel_nxt;
  logic [CODE_W-1:0] r_lat_code, w_lat_code_nxt;
  logic [COLS-1:0]   r_lat_pat, w_lat_pat_nxt;
  logic              w_push;
  logic [CODE_W-1:0] w_push_code;
  logic              w_adv;

  assign w_code_now = CODE_W'(r_row_idx) * CODE_W'(COLS) + CODE_W'(w_first_col);

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_TICKS + 1);
  logic [RPW-1:0]    r_rep_cnt, w_rep_nxt;
`endif

  // Next-state, row advance and push decision; only acts on scan ticks.
  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row_idx;
    w_db_nxt       = r_db_cnt;
    w_rel_nxt      = r_rel_cnt;
    w_lat_code_nxt = r_lat_code;
    w_lat_pat_nxt  = r_lat_pat;
    w_push         = 1'b0;
    w_push_code    = r_lat_code;
    w_adv          = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt      = r_rep_cnt;
`endif
    if (w_tick) begin
      case (r_state)
        S_SCAN: begin
          if (w_c_act == '0) begin
            w_adv = 1'b1;
          end else begin
            w_lat_code_nxt = w_code_now;
            w_lat_pat_nxt  = w_c_act;
            w_db_nxt       = DBW'(1);
            w_rel_nxt      = '0;
            if (DEBOUNCE == 1) begin
              w_push      = 1'b1;
              w_push_code = w_code_now;
              w_state_nxt = S_HELD;
            end else begin
              w_state_nxt = S_DEB;
            end
          end
        end
        S_DEB: begin
          if (w_c_act == r_lat_pat) begin
            w_db_nxt = r_db_cnt + DBW'(1);
            if (w_db_nxt == DBW'(DEBOUNCE)) begin
              w_push      = 1'b1;
              w_rel_nxt   = '0;
              w_state_nxt = S_HELD;
            end
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = S_SCAN;
          end
        end
        S_HELD: begin
          if (w_c_act == '0) begin
            w_rel_nxt = r_rel_cnt + DBW'(1);
            if (w_rel_nxt == DBW'(DEBOUNCE)) begin
              w_adv       = 1'b1;
              w_state_nxt = S_SCAN;
            end
          end else begin
            w_rel_nxt = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (w_c_act == r_lat_pat) begin
            w_rep_nxt = r_rep_cnt + RPW'(1);
            if (w_rep_nxt == RPW'(REPEAT_TICKS)) begin
              w_push    = 1'b1;
              w_rep_nxt = '0;
            end
          end else begin
            w_rep_nxt = '0;
          end
`endif
        end
        default: w_state_nxt = S_SCAN;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    // Counter starts from zero on every entry into HELD.
    if (r_state != S_HELD) w_rep_nxt = '0;
`endif
    if (w_adv)
      w_row_nxt = (r_row_idx == RW'(ROWS - 1)) ? '0 : r_row_idx + RW'(1);
  end

  // FSM state, latched key and registered row drive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_SCAN;
      r_row_idx   <= '0;
      r_row_drive <= ~(ROWS'(1));
      r_db_cnt    <= '0;
      r_rel_cnt   <= '0;
      r_lat_code  <= '0;
      r_lat_pat   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_idx   <= w_row_nxt;
      r_row_drive <= ~(ROWS'(1) << w_row_nxt);
      r_db_cnt    <= w_db_nxt;
      r_rel_cnt   <= w_rel_nxt;
      r_lat_code  <= w_lat_code_nxt;
      r_lat_pat   <= w_lat_pat_nxt;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat interval counter.
  always_ff @(posedge clk) begin
    if (!rst) r_rep_cnt <= '0;
    else      r_rep_cnt <= w_rep_nxt;
  end
`endif

  assign row_drive = r_row_drive;
  assign key_held  = (r_state == S_HELD);

  // ---------------------------------------------------------------- FIFO
  logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic              r_ovf;
  logic              w_empty, w_full, w_pop, w_wr_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && key_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr_en = w_push && (!w_full || w_pop);

  // Storage, pointers and sticky overflow; memory cleared so key_code is 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_push_code;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_push && !w_wr_en) r_ovf <= 1'b1;
    end
  end

  assign key_code  = r_mem[r_rd_ptr[AW-1:0]];
  assign key_valid = !w_empty;
  assign overflow  = r_ovf;

endmodule
